// File: rtl/ddr_mem_ctrl.sv
// ddr_mem_ctrl: memory endpoint for the core's DDR port.
// Accepts one-cycle ddr_* requests and serves them from an internal 64-bit
// array after ACCESS_LATENCY wait cycles. Returns a 64-bit load word, or a
// 512-bit line for burst fetches, with a one-cycle done pulse.
// Optional macro DDR_FAST_SINGLE_EN: single-word requests skip the WAIT state.
module ddr_mem_ctrl #(
  parameter int MEM_DEPTH_LOG2 = 16,
  parameter int ACCESS_LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ddr_chip_enable,
  input  logic [18:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [63:0]  ddr_opstore_write_mask,
  input  logic [63:0]  ddr_opstore_write_data,
  output logic [63:0]  ddr_opload_read_data,
  output logic [511:0] ddr_pc_read_inst,
  output logic         ddr_operation_done,
  output logic         ddr_ready
);

  localparam int AW = MEM_DEPTH_LOG2;
  localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  logic [63:0]   mem [0:(1 << AW) - 1];
  state_t        state;
  logic [3:0]    wait_cnt;
  logic [2:0]    beat;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic          req_burst;
  logic [63:0]   req_mask;
  logic [63:0]   req_data;

  logic          accept;
  logic          accept_fast;
  logic          mem_we;
  logic [AW-1:0] rd_addr;
  logic          unused_index_hi;

  assign accept = ddr_chip_enable && ddr_ready;

`ifdef DDR_FAST_SINGLE_EN
  // Anything except a read burst is a single-word access and may bypass WAIT.
  assign accept_fast = !(ddr_burst_mode && !ddr_write_enable);
`else
  assign accept_fast = 1'b0;
`endif

  // Index bits above the array depth are ignored, so addresses wrap.
  generate
    if (AW < 19) begin : g_index_hi
      assign unused_index_hi = ^ddr_index[18:AW];
    end else begin : g_index_full
      assign unused_index_hi = 1'b0;
    end
  endgenerate

  // Stores land in the single XFER cycle; bursts walk the aligned 8-word line.
  assign mem_we  = (state == S_XFER) && req_we;
  assign rd_addr = req_burst ? {req_addr[AW-1:3], beat} : req_addr;

  // Array write port: read-modify-write under the per-bit mask.
  // NOTE: the storage array is deliberately left out of reset so contents
  // survive reset_n and the array can map onto RAM primitives.
  always_ff @(posedge clock) begin
    if (mem_we)
      mem[req_addr] <= (mem[req_addr] & ~req_mask) | (req_data & req_mask);
  end

  // Request FSM with registered ready/done and read result registers.
  // NOTE: every state element here is assigned with <= so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      wait_cnt             <= '0;
      beat                 <= '0;
      req_addr             <= '0;
      req_we               <= 1'b0;
      req_burst            <= 1'b0;
      req_mask             <= '0;
      req_data             <= '0;
      ddr_ready            <= 1'b1;
      ddr_operation_done   <= 1'b0;
      ddr_opload_read_data <= '0;
      ddr_pc_read_inst     <= '0;
    end else begin
      ddr_operation_done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            req_addr  <= ddr_index[AW-1:0];
            req_we    <= ddr_write_enable;
            // A burst store degrades to a single masked store.
            req_burst <= ddr_burst_mode && !ddr_write_enable;
            req_mask  <= ddr_opstore_write_mask;
            req_data  <= ddr_opstore_write_data;
            wait_cnt  <= WAIT_LOAD;
            beat      <= '0;
            ddr_ready <= 1'b0;
            state     <= accept_fast ? S_XFER : S_WAIT;
          end else begin
            ddr_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_XFER;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        S_XFER: begin
          if (req_burst) begin
            ddr_pc_read_inst[64*beat +: 64] <= mem[rd_addr];
            beat <= beat + 3'd1;
            if (beat == 3'd7) begin
              state              <= S_DONE;
              ddr_operation_done <= 1'b1;
              ddr_ready          <= 1'b1;
            end
          end else begin
            if (!req_we) ddr_opload_read_data <= mem[rd_addr];
            state              <= S_DONE;
            ddr_operation_done <= 1'b1;
            ddr_ready          <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          ddr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_mem_ctrl.sv
// tb_ddr_mem_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a word-array reference model.
module tb_ddr_mem_ctrl;

  localparam int L     = 4;
  localparam int DEPTH = 1 << 16;
`ifdef DDR_FAST_SINGLE_EN
  localparam int LAT_SINGLE = 2;
`else
  localparam int LAT_SINGLE = L + 2;
`endif
  localparam int LAT_BURST = L + 9;
  localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         ddr_chip_enable;
  logic [18:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [63:0]  ddr_opstore_write_mask;
  logic [63:0]  ddr_opstore_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;

  always #5 clock = ~clock;

  ddr_mem_ctrl #(.MEM_DEPTH_LOG2(16), .ACCESS_LATENCY(L)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .ddr_chip_enable        (ddr_chip_enable),
    .ddr_index              (ddr_index),
    .ddr_write_enable       (ddr_write_enable),
    .ddr_burst_mode         (ddr_burst_mode),
    .ddr_opstore_write_mask (ddr_opstore_write_mask),
    .ddr_opstore_write_data (ddr_opstore_write_data),
    .ddr_opload_read_data   (ddr_opload_read_data),
    .ddr_pc_read_inst       (ddr_pc_read_inst),
    .ddr_operation_done     (ddr_operation_done),
    .ddr_ready              (ddr_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain word array keyed by wrapped address.
  logic [63:0]  model_mem [int];
  logic [63:0]  exp_load;
  logic [511:0] exp_line;

  function automatic logic [63:0] model_rd(input int a);
    return model_mem.exists(a) ? model_mem[a] : 64'h0;
  endfunction

  task automatic model_apply(input logic we, input logic burst, input logic [18:0] idx,
                             input logic [63:0] mask, input logic [63:0] data);
    int a;
    int base;
    a = int'(idx) % DEPTH;
    if (we) begin
      model_mem[a] = (model_rd(a) & ~mask) | (data & mask);
    end else if (burst) begin
      base = a - (a % 8);
      for (int k = 0; k < 8; k++) exp_line[64*k +: 64] = model_rd(base + k);
    end else begin
      exp_load = model_rd(a);
    end
  endtask

  // Issue one request at a negedge and wait (bounded) for done; lat counts
  // cycles after the accept edge, -1 on timeout. Returns at done's negedge.
  task automatic do_req(input logic we, input logic burst, input logic [18:0] idx,
                        input logic [63:0] mask, input logic [63:0] data, output int lat);
    check("ready_before_req", ddr_ready, 1'b1);
    ddr_chip_enable        = 1'b1;
    ddr_write_enable       = we;
    ddr_burst_mode         = burst;
    ddr_index              = idx;
    ddr_opstore_write_mask = mask;
    ddr_opstore_write_data = data;
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    lat = 1;
    check("ready_busy", ddr_ready, 1'b0);
    while (ddr_operation_done !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (ddr_operation_done !== 1'b1) lat = -1;
  endtask

  task automatic run_op(input string tag, input logic we, input logic burst, input logic [18:0] idx,
                        input logic [63:0] mask, input logic [63:0] data);
    int lat;
    int exp_lat;
    model_apply(we, burst, idx, mask, data);
    exp_lat = (burst && !we) ? LAT_BURST : LAT_SINGLE;
    do_req(we, burst, idx, mask, data, lat);
    check({tag, "_latency"}, 512'(lat), 512'(exp_lat));
    check({tag, "_load"}, ddr_opload_read_data, exp_load);
    check({tag, "_line"}, ddr_pc_read_inst, exp_line);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic        burst;
    logic [18:0] idx;
    logic [63:0] mask;
    logic [63:0] data;
    logic [63:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];
  int   lat;
  int   poke;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ddr_chip_enable        = 1'b0;
    ddr_write_enable       = 1'b0;
    ddr_burst_mode         = 1'b0;
    ddr_index              = '0;
    ddr_opstore_write_mask = '0;
    ddr_opstore_write_data = '0;
    exp_load               = '0;
    exp_line               = '0;

    vecs[0] = '{"pre_aaaa",  1'b1, 1'b0, 19'h00010, FULL, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, LAT_SINGLE};
    vecs[1] = '{"mask_st",   1'b1, 1'b0, 19'h00010, 64'h0000_0000_FFFF_FFFF, 64'h1122_3344_5566_7788,
                64'h0, LAT_SINGLE};
    vecs[2] = '{"mask_rd",   1'b0, 1'b0, 19'h00010, 64'h0, 64'h0, 64'hAAAA_AAAA_5566_7788, LAT_SINGLE};
    vecs[3] = '{"wrap_st",   1'b1, 1'b0, 19'h10005, FULL, 64'h5A, 64'hAAAA_AAAA_5566_7788, LAT_SINGLE};
    vecs[4] = '{"wrap_rd",   1'b0, 1'b0, 19'h00005, 64'h0, 64'h0, 64'h5A, LAT_SINGLE};
    vecs[5] = '{"burst_st",  1'b1, 1'b1, 19'h00021, FULL, 64'hDEAD_BEEF, 64'h5A, LAT_SINGLE};
    vecs[6] = '{"burst_st_rd", 1'b0, 1'b0, 19'h00021, 64'h0, 64'h0, 64'hDEAD_BEEF, LAT_SINGLE};

    // Reset state.
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_ready", ddr_ready, 1'b1);
    check("reset_done", ddr_operation_done, 1'b0);
    check("reset_load", ddr_opload_read_data, 64'h0);
    check("reset_line", ddr_pc_read_inst, 512'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      model_apply(vecs[i].we, vecs[i].burst, vecs[i].idx, vecs[i].mask, vecs[i].data);
      do_req(vecs[i].we, vecs[i].burst, vecs[i].idx, vecs[i].mask, vecs[i].data, lat);
      check({vecs[i].name, "_latency"}, 512'(lat), 512'(vecs[i].exp_lat));
      check({vecs[i].name, "_load"}, ddr_opload_read_data, vecs[i].exp_rd);
      check({vecs[i].name, "_line_untouched"}, ddr_pc_read_inst, 512'h0);
    end

    // Burst line read of an unaligned index.
    for (int k = 0; k < 8; k++) run_op("burst_pre", 1'b1, 1'b0, 19'(16 + k), FULL, 64'(16 + k));
    run_op("burst", 1'b0, 1'b1, 19'h00013, 64'h0, 64'h0);
    check("burst_beat0", ddr_pc_read_inst[63:0], 64'h10);
    check("burst_beat7", ddr_pc_read_inst[511:448], 64'h17);
    @(negedge clock);
    check("burst_done_one_cycle", ddr_operation_done, 1'b0);

    // Strobe while busy is ignored; then a back-to-back read in DONE.
    run_op("busy_pre", 1'b1, 1'b0, 19'h00030, FULL, 64'h1111);
    model_apply(1'b0, 1'b0, 19'h00030, 64'h0, 64'h0);
    poke = (LAT_SINGLE == 2) ? 1 : 2;
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = 1'b0;
    ddr_burst_mode   = 1'b0;
    ddr_index        = 19'h00030;
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    lat = 1;
    while (ddr_operation_done !== 1'b1 && lat < 40) begin
      if (lat == poke) begin
        ddr_chip_enable        = 1'b1;
        ddr_write_enable       = 1'b1;
        ddr_opstore_write_mask = FULL;
        ddr_opstore_write_data = 64'h2222;
      end else begin
        ddr_chip_enable = 1'b0;
      end
      @(negedge clock);
      lat++;
    end
    ddr_chip_enable = 1'b0;
    check("busy_latency", 512'(lat), 512'(LAT_SINGLE));
    check("busy_load", ddr_opload_read_data, 64'h1111);
    run_op("b2b_read", 1'b0, 1'b0, 19'h00030, 64'h0, 64'h0);
    check("b2b_value", ddr_opload_read_data, 64'h1111);

    // Reset in the middle of a burst.
    @(negedge clock);
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = 1'b0;
    ddr_burst_mode   = 1'b1;
    ddr_index        = 19'h00010;
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    lat = 1;
    repeat (6) begin
      check("rst_mid_pre_done", ddr_operation_done, 1'b0);
      @(negedge clock);
      lat++;
    end
    reset_n = 1'b0;
    #1;
    check("rst_mid_ready", ddr_ready, 1'b1);
    check("rst_mid_done", ddr_operation_done, 1'b0);
    check("rst_mid_load", ddr_opload_read_data, 64'h0);
    check("rst_mid_line", ddr_pc_read_inst, 512'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
    exp_load = '0;
    exp_line = '0;
    repeat (12) begin
      @(negedge clock);
      check("rst_mid_no_done", ddr_operation_done, 1'b0);
      check("rst_mid_ready_after", ddr_ready, 1'b1);
    end
    run_op("rst_survive", 1'b0, 1'b0, 19'h00010, 64'h0, 64'h0);
    check("rst_survive_value", ddr_opload_read_data, 64'h10);

    // Randomized traffic over a small aligned window with random high bits.
    for (int i = 0; i < 32; i++) run_op("rnd_init", 1'b1, 1'b0, 19'(32 + i), FULL, {$urandom, $urandom});
    for (int i = 0; i < 250; i++) begin
      logic        we;
      logic        burst;
      logic [18:0] idx;
      logic [63:0] mask;
      we    = 1'($urandom);
      burst = 1'($urandom);
      idx   = {3'($urandom), 16'(32 + $urandom_range(0, 31))};
      case ($urandom_range(0, 3))
        0:       mask = FULL;
        1:       mask = 64'h0;
        default: mask = {$urandom, $urandom};
      endcase
      run_op("rnd", we, burst, idx, mask, {$urandom, $urandom});
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
